// File: rtl/sr_pkg.sv
// Shared definitions for the SR latch drive controller: FSM state encoding,
// default timing parameters and the counter load helper.
package sr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_PULSE = 2'd2,
    ST_CHECK = 2'd3
  } sr_state_e;

  localparam int DEF_PULSE_CYCLES   = 2;
  localparam int DEF_GAP_CYCLES     = 1;
  localparam int DEF_TIMEOUT_CYCLES = 8;

  localparam int CNT_W = 8;

  // A phase lasting N cycles loads N-1 and ends on the cycle the counter reads zero.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    if (cycles <= 0) return '0;
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sr_cycle_counter.sv
// Loadable 8-bit down-counter with a zero flag; times the GAP, PULSE and
// CHECK phases of sr_drive_ctrl.
module sr_cycle_counter
  import sr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: load has priority, decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sr_drive_ctrl.sv
// SR latch drive controller: accepts set/reset commands, inserts dead time,
// pulses S or R, then waits for the latch readback to confirm or time out.
// Optional feature macro: SR_DRIVE_SKIP_REDUNDANT_EN -- when defined, a command
// that asks for the level already confirmed (and no error pending) completes
// on the next cycle without driving the latch.
module sr_drive_ctrl
  import sr_pkg::*;
#(
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  input  logic q_fb,
  input  logic err_clr,
  output logic S,
  output logic R,
  output logic done,
  output logic err,
  output logic level
);

  localparam logic [CNT_W-1:0] GAP_LOAD     = cnt_load(GAP_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LOAD   = cnt_load(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = cnt_load(TIMEOUT_CYCLES);

  sr_state_e state_q, state_d;
  logic target_q, target_d;
  logic s_q, s_d;
  logic r_q, r_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic level_q, level_d;

  logic             cnt_load_en;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             skip;

  sr_cycle_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load_en),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Redundant-command detection; only active with the optional feature built in.
`ifdef SR_DRIVE_SKIP_REDUNDANT_EN
  assign skip = (req_level == level_q) && !err_q;
`else
  assign skip = 1'b0;
`endif

  // Next-state, counter control and registered-output next values.
  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    done_d       = 1'b0;
    err_d        = err_q;
    level_d      = level_q;
    cnt_load_en  = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    // Clear first so a timeout on the same cycle still wins.
    if (err_clr) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          target_d = req_level;
          if (skip) begin
            done_d = 1'b1;
          end else if (GAP_CYCLES == 0) begin
            state_d      = ST_PULSE;
            cnt_load_en  = 1'b1;
            cnt_load_val = PULSE_LOAD;
          end else begin
            state_d      = ST_GAP;
            cnt_load_en  = 1'b1;
            cnt_load_val = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_d      = ST_PULSE;
          cnt_load_en  = 1'b1;
          cnt_load_val = PULSE_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_d      = ST_CHECK;
          cnt_load_en  = 1'b1;
          cnt_load_val = TIMEOUT_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_CHECK: begin
        if (q_fb == target_q) begin
          done_d  = 1'b1;
          level_d = target_q;
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Drives follow the next state, so S/R are registered and mutually exclusive by construction.
    s_d = (state_d == ST_PULSE) &&  target_d;
    r_d = (state_d == ST_PULSE) && !target_d;
  end

  // State and output registers; reset forces the latch drives low immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      s_q      <= s_d;
      r_q      <= r_d;
      done_q   <= done_d;
      err_q    <= err_d;
      level_q  <= level_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign S         = s_q;
  assign R         = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign level     = level_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl with default parameters and a behavioural
// SR latch model on q_fb. Cycle numbering: the accept edge ends cycle 0.
module tb_sr_drive_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_level, req_ready;
  logic q_fb, err_clr;
  logic s, r, done, err, level;

  logic latch_q = 1'b0;
  logic stuck_en;

  int total = 0;
  int bad   = 0;

  sr_drive_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_level (req_level),
    .req_ready (req_ready),
    .q_fb      (q_fb),
    .err_clr   (err_clr),
    .S         (s),
    .R         (r),
    .done      (done),
    .err       (err),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Latch model: follows S/R on the clock; stuck_en forces the readback low.
  always @(posedge clk) begin
    if (s)      latch_q <= 1'b1;
    else if (r) latch_q <= 1'b0;
  end
  assign q_fb = stuck_en ? 1'b0 : latch_q;

  // S and R must never be high together.
  always @(negedge clk) begin
    total++;
    if (s && r) begin
      bad++;
      $display("FAIL s_r_exclusive: S=%b R=%b expected not both 1", s, r);
    end
  end

  assert property (@(posedge clk) !(s && r));

  // Issue one command and record S/R/done/req_ready for cycles 1..ncyc (bit c = cycle c).
  task automatic run_cmd(input logic lvl, input int ncyc, output logic rdy0,
                         output logic [15:0] sv, output logic [15:0] rv,
                         output logic [15:0] dv, output logic [15:0] yv);
    sv = '0; rv = '0; dv = '0; yv = '0;
    @(negedge clk);
    rdy0      = req_ready;
    req_valid = 1'b1;
    req_level = lvl;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      sv[c] = s; rv[c] = r; dv[c] = done; yv[c] = req_ready;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_level = 1'b0; err_clr = 1'b0; stuck_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total += 5;
    if (s !== 1'b0)     begin bad++; $display("FAIL reset_s: got %b expected 0", s); end
    if (r !== 1'b0)     begin bad++; $display("FAIL reset_r: got %b expected 0", r); end
    if (done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    if (err !== 1'b0)   begin bad++; $display("FAIL reset_err: got %b expected 0", err); end
    if (level !== 1'b0) begin bad++; $display("FAIL reset_level: got %b expected 0", level); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_set();
    logic rdy0;
    logic [15:0] sv, rv, dv, yv;
    run_cmd(1'b1, 5, rdy0, sv, rv, dv, yv);
    total += 6;
    if (rdy0 !== 1'b1)    begin bad++; $display("FAIL set_ready_before: got %b expected 1", rdy0); end
    if (sv !== 16'h000C)  begin bad++; $display("FAIL set_s_cycles: got %h expected 000c", sv); end
    if (rv !== 16'h0000)  begin bad++; $display("FAIL set_r_cycles: got %h expected 0000", rv); end
    if (dv !== 16'h0020)  begin bad++; $display("FAIL set_done_cycles: got %h expected 0020", dv); end
    if (yv !== 16'h0020)  begin bad++; $display("FAIL set_ready_cycles: got %h expected 0020", yv); end
    if (level !== 1'b1)   begin bad++; $display("FAIL set_level: got %b expected 1", level); end
  endtask

  task automatic test_redundant();
    logic rdy0;
    logic [15:0] sv, rv, dv, yv;
`ifdef SR_DRIVE_SKIP_REDUNDANT_EN
    run_cmd(1'b1, 2, rdy0, sv, rv, dv, yv);
    total += 4;
    if (sv !== 16'h0000) begin bad++; $display("FAIL skip_s_cycles: got %h expected 0000", sv); end
    if (rv !== 16'h0000) begin bad++; $display("FAIL skip_r_cycles: got %h expected 0000", rv); end
    if (dv !== 16'h0002) begin bad++; $display("FAIL skip_done_cycles: got %h expected 0002", dv); end
    if (yv !== 16'h0006) begin bad++; $display("FAIL skip_ready_cycles: got %h expected 0006", yv); end
`else
    run_cmd(1'b1, 5, rdy0, sv, rv, dv, yv);
    total += 3;
    if (sv !== 16'h000C) begin bad++; $display("FAIL repeat_s_cycles: got %h expected 000c", sv); end
    if (rv !== 16'h0000) begin bad++; $display("FAIL repeat_r_cycles: got %h expected 0000", rv); end
    if (dv !== 16'h0020) begin bad++; $display("FAIL repeat_done_cycles: got %h expected 0020", dv); end
`endif
    total++;
    if (level !== 1'b1) begin bad++; $display("FAIL repeat_level: got %b expected 1", level); end
  endtask

  task automatic test_clear();
    logic rdy0;
    logic [15:0] sv, rv, dv, yv;
    run_cmd(1'b0, 5, rdy0, sv, rv, dv, yv);
    total += 4;
    if (sv !== 16'h0000) begin bad++; $display("FAIL clr_s_cycles: got %h expected 0000", sv); end
    if (rv !== 16'h000C) begin bad++; $display("FAIL clr_r_cycles: got %h expected 000c", rv); end
    if (dv !== 16'h0020) begin bad++; $display("FAIL clr_done_cycles: got %h expected 0020", dv); end
    if (level !== 1'b0)  begin bad++; $display("FAIL clr_level: got %b expected 0", level); end
  endtask

  // Set with readback stuck at 0: CHECK runs cycles 4..11, err rises in cycle 12.
  // err_clr is held during cycle 11 so it coincides with the timeout edge.
  task automatic test_timeout();
    logic [15:0] sv, dv;
    logic err11, err12, rdy12;
    sv = '0; dv = '0;
    stuck_en = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_level = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      sv[c] = s; dv[c] = done;
      if (c == 11) begin
        err11   = err;
        err_clr = 1'b1;
      end
      if (c == 12) begin
        err12   = err;
        rdy12   = req_ready;
        err_clr = 1'b0;
      end
    end
    total += 6;
    if (sv !== 16'h000C) begin bad++; $display("FAIL to_s_cycles: got %h expected 000c", sv); end
    if (dv !== 16'h0000) begin bad++; $display("FAIL to_done_cycles: got %h expected 0000", dv); end
    if (err11 !== 1'b0)  begin bad++; $display("FAIL to_err_early: got %b expected 0", err11); end
    if (err12 !== 1'b1)  begin bad++; $display("FAIL to_err_with_clr: got %b expected 1", err12); end
    if (rdy12 !== 1'b1)  begin bad++; $display("FAIL to_ready: got %b expected 1", rdy12); end
    if (level !== 1'b0)  begin bad++; $display("FAIL to_level: got %b expected 0", level); end
    stuck_en = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b expected 1", err); end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clr: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid_pulse();
    logic rdy0;
    logic [15:0] sv, rv, dv, yv;
    run_cmd(1'b1, 2, rdy0, sv, rv, dv, yv);
    total++;
    if (sv[2] !== 1'b1) begin bad++; $display("FAIL mid_s_before: got %b expected 1", sv[2]); end
    #2;
    rst_n = 1'b0;
    #1;
    total += 3;
    if (s !== 1'b0)         begin bad++; $display("FAIL mid_s_async: got %b expected 0", s); end
    if (level !== 1'b0)     begin bad++; $display("FAIL mid_level: got %b expected 0", level); end
    if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_in_reset: got %b expected 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total += 2;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after: got %b expected 1", req_ready); end
    if (s !== 1'b0)         begin bad++; $display("FAIL mid_s_after: got %b expected 0", s); end
  endtask

  // req_valid held for 40 cycles with alternating levels: one command per 5 cycles.
  task automatic test_back_to_back();
    logic rdy, prev_sr, seen;
    int zeros, dones, gap_bad;
    prev_sr = 1'b0; seen = 1'b0; zeros = 0; dones = 0; gap_bad = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_level = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) req_level = ~req_level;
      if (done) dones++;
      if (s || r) begin
        if (!prev_sr && seen && (zeros < 1)) gap_bad++;
        seen  = 1'b1;
        zeros = 0;
      end else begin
        zeros++;
      end
      prev_sr = s || r;
      @(negedge clk);
    end
    req_valid = 1'b0;
    total += 2;
    if (dones !== 8)   begin bad++; $display("FAIL b2b_done_count: got %0d expected 8", dones); end
    if (gap_bad !== 0) begin bad++; $display("FAIL b2b_dead_time: got %0d short gaps expected 0", gap_bad); end
  endtask

  initial begin
    test_reset();
    test_set();
    test_redundant();
    test_clear();
    test_timeout();
    test_reset_mid_pulse();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
